// File: rtl/mips_ctrl_seq.sv
// mips_ctrl_seq -- multi-cycle MIPS decode/control sequencer.
//
// Accepts one instruction word per valid/ready handshake, decodes it into
// register addresses, ALU op, immediate and operand-B select, holds those
// fields stable through EXEC and WB, issues a single register-file write
// pulse in WB and captures the ALU flags there.
//
// Sequence: IDLE -> DECODE -> EXEC (EXEC_CYCLES cycles) -> WB -> IDLE.
//
// Parameters:
//   EXEC_CYCLES   cycles spent in EXEC before WB (1..15)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr, instr_valid       instruction word and its valid strobe
//   instr_ready              high in IDLE: an instruction can be accepted
//   Read1, Read2, Write      rs, rt and destination register addresses
//   op, inm, sel             ALU op, immediate, 1 = operand B is immediate
//   reg_we                   register-file write enable (one-cycle pulse)
//   zero, overflow, carry    ALU flags, sampled in WB
//   status                   {carry, overflow, zero} captured in WB
//   illegal                  last instruction undecodable (sticky)
//   done                     one-cycle retire pulse
//   trap                     overflow trap pulse
//
// Optional feature macro: MIPS_CTRL_OVF_TRAP_EN
//   defined   : ADD/SUB overflow in WB suppresses reg_we and pulses trap
//   undefined : trap tied 0, overflow only recorded in status

module mips_ctrl_seq #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [4:0]  Read1,
    output logic [4:0]  Read2,
    output logic [4:0]  Write,
    output logic [3:0]  op,
    output logic [15:0] inm,
    output logic        sel,
    output logic        reg_we,
    input  logic        zero,
    input  logic        overflow,
    input  logic        carry,
    output logic [2:0]  status,
    output logic        illegal,
    output logic        done,
    output logic        trap
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instr;
    logic [3:0]  r_cnt;
    logic [4:0]  r_read1;
    logic [4:0]  r_read2;
    logic [4:0]  r_write;
    logic [3:0]  r_op;
    logic [15:0] r_inm;
    logic        r_sel;
    logic        r_illegal;
    logic [2:0]  r_status;

    logic [5:0]  w_opc;
    logic [5:0]  w_funct;
    logic [3:0]  w_op;
    logic [4:0]  w_write;
    logic        w_sel;
    logic        w_ill;
    logic        w_wb;
    logic        w_trap;

    assign w_opc   = r_instr[31:26];
    assign w_funct = r_instr[5:0];

    // Decode of the latched instruction; only consumed while in DECODE.
    always_comb begin
        w_op    = OP_AND;
        w_write = 5'd0;
        w_sel   = 1'b0;
        w_ill   = 1'b0;
        if (w_opc == 6'h00) begin
            w_write = r_instr[15:11];
            case (w_funct)
                6'h20:   w_op = OP_ADD;
                6'h22:   w_op = OP_SUB;
                6'h24:   w_op = OP_AND;
                6'h25:   w_op = OP_OR;
                6'h27:   w_op = OP_NOR;
                6'h2A:   w_op = OP_SLT;
                default: w_ill = 1'b1;
            endcase
        end else begin
            w_write = r_instr[20:16];
            w_sel   = 1'b1;
            case (w_opc)
                6'h08:   w_op = OP_ADD;
                6'h0C:   w_op = OP_AND;
                6'h0D:   w_op = OP_OR;
                6'h0A:   w_op = OP_SLT;
                default: w_ill = 1'b1;
            endcase
        end
        // An undecodable word must never reach the register file.
        if (w_ill) begin
            w_op    = OP_AND;
            w_write = 5'd0;
            w_sel   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (instr_valid) w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   if (r_cnt == 4'd0) w_next = S_WB;
            S_WB:     w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr   <= 32'd0;
            r_cnt     <= 4'd0;
            r_read1   <= 5'd0;
            r_read2   <= 5'd0;
            r_write   <= 5'd0;
            r_op      <= 4'd0;
            r_inm     <= 16'd0;
            r_sel     <= 1'b0;
            r_illegal <= 1'b0;
            r_status  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr   <= instr;
                        r_illegal <= 1'b0;
                    end
                end
                S_DECODE: begin
                    r_read1   <= r_instr[25:21];
                    r_read2   <= r_instr[20:16];
                    r_inm     <= r_instr[15:0];
                    r_write   <= w_write;
                    r_op      <= w_op;
                    r_sel     <= w_sel;
                    r_illegal <= w_ill;
                    r_cnt     <= CNT_LOAD;
                end
                S_EXEC: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                S_WB: begin
                    r_status <= {carry, overflow, zero};
                end
                default: ;
            endcase
        end
    end

    // WB pulses are gated by rst so an instruction aborted in WB never retires.
    assign w_wb = (r_state == S_WB) && !rst;

`ifdef MIPS_CTRL_OVF_TRAP_EN
    assign w_trap = w_wb && overflow && ((r_op == OP_ADD) || (r_op == OP_SUB));
`else
    assign w_trap = 1'b0;
`endif

    assign instr_ready = (r_state == S_IDLE);
    assign reg_we      = w_wb && !r_illegal && (r_write != 5'd0) && !w_trap;
    assign done        = w_wb;
    assign trap        = w_trap;
    assign Read1       = r_read1;
    assign Read2       = r_read2;
    assign Write       = r_write;
    assign op          = r_op;
    assign inm         = r_inm;
    assign sel         = r_sel;
    assign illegal     = r_illegal;
    assign status      = r_status;

endmodule
